// File: rtl/if_id_queue.sv
// if_id_queue: in-order {pc, instruction} queue sitting between IF and ID.
// It lets ID stall without dropping fetched words and discards everything
// on a control-flow flush. Every output is a flop loaded from next-state logic.
//
// Ports:
//   clk, RST              clock; asynchronous active-high reset
//   in_valid/in_pc/in_instr/in_ready     fetch-side handshake
//   flush                 synchronous discard of all entries
//   out_valid/out_pc/out_instr/out_ready decode-side handshake
//   count                 occupied entries, 0..DEPTH
module if_id_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic            enq, deq;
  entry_t          head;

  // Next-state logic. The output registers are loaded with the entry that will
  // be at the head after this edge. A word written into an empty queue
  // therefore appears on out_* the cycle after it is accepted.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    enq         = in_valid && in_ready_q && !flush;
    deq         = out_valid_q && out_ready && !flush;
    head        = '0;
    out_pc_d    = '0;
    out_instr_d = '0;

    if (enq) begin
      mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CW'(1);
    end

    out_valid_d = (count_d != CW'(0));
    in_ready_d  = (count_d != CW'(DEPTH));
    head        = mem_d[rd_ptr_d];
    // An empty queue presents a NOP bubble (instruction 0) with pc 0.
    if (out_valid_d) begin
      out_pc_d    = head.pc;
      out_instr_d = head.instr;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed bench for if_id_queue (DEPTH=2).
// Inputs change 1ns after each rising edge. Outputs are sampled at the same point.
module tb_if_id_queue;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [1:0]  count;

  int vectors = 0;
  int errs    = 0;

  if_id_queue #(.DEPTH(2), .AW(1)) dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks count, out_valid and in_ready, plus out_pc and out_instr.
  task automatic chk_state(input string tag, input int cnt, input logic [31:0] pc,
                           input logic [31:0] instr);
    chk({tag, ".count"},     32'(count),     32'(cnt));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(cnt != 0));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(cnt != 2));
    chk({tag, ".out_pc"},    out_pc,         pc);
    chk({tag, ".out_instr"}, out_instr,      instr);
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
  endtask

  // Wrap-around table: in_valid, pc, out_ready, then the expected count and head pc.
  // The instruction for each word is its pc + 0x1000.
  logic        w_iv   [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  logic [31:0] w_pc   [11] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'h0,
                               32'h10, 32'h14, 32'h18, 32'h0, 32'h0};
  logic        w_or   [11] = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 1};
  int          w_cnt  [11] = '{1, 1, 2, 1, 2, 1, 1, 1, 2, 1, 0};
  logic [31:0] w_head [11] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'hC,
                               32'h10, 32'h14, 32'h14, 32'h18, 32'h0};

  initial begin
    RST = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    // Assert reset between edges. The outputs must respond immediately.
    RST = 1'b1;
    #1;
    chk_state("reset_async", 0, 32'h0, 32'h0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk_state("idle_after_reset", 0, 32'h0, 32'h0);

    // Streaming with ID always ready.
    drive(1'b1, 32'h0, 32'h20080005, 1'b1);
    tick();
    chk_state("stream0", 1, 32'h0, 32'h20080005);
    drive(1'b1, 32'h4, 32'h2009000A, 1'b1);
    tick();
    chk_state("stream1", 1, 32'h4, 32'h2009000A);
    drive(1'b1, 32'h8, 32'h01095020, 1'b1);
    tick();
    chk_state("stream2", 1, 32'h8, 32'h01095020);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_state("stream_drain", 0, 32'h0, 32'h0);

    // An empty queue with out_ready high must not change state.
    tick();
    chk_state("empty_ready", 0, 32'h0, 32'h0);

    // Stall and fill.
    drive(1'b1, 32'h0, 32'h1000, 1'b0);
    tick();
    chk_state("fill0", 1, 32'h0, 32'h1000);
    drive(1'b1, 32'h4, 32'h1004, 1'b0);
    tick();
    chk_state("fill1", 2, 32'h0, 32'h1000);
    drive(1'b1, 32'h8, 32'h1008, 1'b0);
    tick();
    chk_state("full_hold", 2, 32'h0, 32'h1000);
    tick();
    chk_state("full_hold2", 2, 32'h0, 32'h1000);
    // The queue is full, so it dequeues but does not accept pc 0x8 on this edge.
    out_ready = 1'b1;
    tick();
    chk_state("drain0", 1, 32'h4, 32'h1004);
    tick();
    chk_state("drain1_accept8", 1, 32'h8, 32'h1008);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_state("drain2", 0, 32'h0, 32'h0);

    // Wrap-around ordering.
    for (int i = 0; i < 11; i++) begin
      drive(w_iv[i], w_pc[i], w_pc[i] + 32'h1000, w_or[i]);
      tick();
      chk_state($sformatf("wrap%0d", i), w_cnt[i], w_head[i],
                (w_cnt[i] != 0) ? w_head[i] + 32'h1000 : 32'h0);
    end

    // Flush while full with a concurrent enqueue and dequeue.
    drive(1'b1, 32'h20, 32'h2020, 1'b0);
    tick();
    drive(1'b1, 32'h24, 32'h2024, 1'b0);
    tick();
    chk_state("pre_flush", 2, 32'h20, 32'h2020);
    drive(1'b1, 32'h40, 32'h2040, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_state("flush", 0, 32'h0, 32'h0);
    drive(1'b1, 32'h100, 32'h2100, 1'b0);
    tick();
    chk_state("post_flush", 1, 32'h100, 32'h2100);

    // Simultaneous enqueue and dequeue with count at 1.
    drive(1'b1, 32'h104, 32'h2104, 1'b1);
    tick();
    chk_state("simul", 1, 32'h104, 32'h2104);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk_state("simul_drain", 0, 32'h0, 32'h0);

    // Reset in the middle of operation discards the queued word.
    drive(1'b1, 32'h200, 32'h2200, 1'b0);
    tick();
    chk_state("pre_reset", 1, 32'h200, 32'h2200);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk_state("mid_reset", 0, 32'h0, 32'h0);
    tick();
    RST = 1'b0;
    drive(1'b1, 32'h300, 32'h2300, 1'b0);
    tick();
    chk_state("after_reset", 1, 32'h300, 32'h2300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch stage (pc + instruction memory) and the decode stage of the pipelined MIPS-style CPU.
- Captures each fetched {pc, instruction} pair and presents it in order to ID with a valid/ready handshake.
- Absorbs ID stalls without losing fetched words; discards all queued words on a control-flow flush.

Parameters:
- DEPTH, 2: number of entries; must be a power of two and at least 2.
- AW, 1: pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch stage presents a word this cycle.
- in_pc  input  32  pc of the fetched word.
- in_instr  input  32  fetched instruction.
- in_ready  output  1  queue accepts a word this cycle.
- flush  input  1  branch/jump redirect; discard all entries.
- out_valid  output  1  head entry is valid for ID.
- out_pc  output  32  pc of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_ready  input  1  ID consumes the head this cycle; low means ID is stalled.
- count  output  AW+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (RST=1, asynchronous, independent of clk):
  - wr_ptr=0, rd_ptr=0, count=0.
  - All storage entries cleared to 0.
  - Outputs during and after reset: out_valid=0, out_pc=0, out_instr=0, in_ready=1.
  - Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer of DEPTH entries, 64 bits each ({pc, instr}); read and write pointers wrap from DEPTH-1 to 0.
- Enqueue: when in_valid && in_ready && !flush at a rising edge:
  - Write the entry at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Dequeue: when out_valid && out_ready && !flush at a rising edge:
  - rd_ptr increments modulo DEPTH.
- count:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
  - When full, no enqueue occurs in that cycle even if ID dequeues in the same cycle.
- out_valid = (count != 0). No combinational path from in_valid.
- out_pc/out_instr:
  - Driven from the entry at rd_ptr when out_valid=1.
  - Forced to 32'h0 when out_valid=0, so an empty queue presents a NOP bubble (instruction 0 = sll $0,$0,0).
- Latency: a word enqueued at edge N appears at out_* with out_valid=1 after edge N (first cycle after acceptance). No same-cycle bypass from in_* to out_*.
- Flush (synchronous, sampled at the rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Any concurrent enqueue or dequeue in that cycle is ignored; the incoming word is dropped.
  - After the edge, out_valid=0, out_instr=0, in_ready=1.
  - Storage contents need not be cleared.
- Empty plus out_ready=1: no state change; rd_ptr does not advance.
- Full plus in_valid=1: word not accepted. The fetch stage must hold pc (halt path) until in_ready=1.
- Holding rule: while out_valid=1 and out_ready=0, out_pc/out_instr remain stable cycle to cycle.
- Ordering: strict FIFO; words leave in exactly the order accepted, across pointer wrap.

Test Plan:
- Reset then idle: assert RST asynchronously between edges -> out_valid=0, out_instr=0, count=0, in_ready=1 immediately; these hold after release with in_valid=0.
- Streaming: out_ready=1, enqueue (0x0,0x20080005), (0x4,0x2009000A), (0x8,0x01095020) on consecutive edges -> each appears one cycle after its acceptance, in order; count stays at most 1.
- Stall and fill: out_ready=0, enqueue pcs 0x0 and 0x4 -> count=2, in_ready=0; a third word at pc 0x8 is not accepted. out_pc holds 0x0 throughout. Raise out_ready -> 0x0 then 0x4 drain, then 0x8 is accepted once in_ready=1.
- Wrap-around: 7 alternating enqueue/dequeue patterns with pcs 0x0..0x18 -> output sequence exactly 0x0..0x18 with no duplicates or skips.
- Flush while full plus concurrent enqueue: count=2, flush=1, in_valid=1 with pc 0x40 -> after the edge, count=0 and out_valid=0. Next enqueue of pc 0x100 is the first word output.
- Simultaneous enqueue and dequeue at count=1: count stays 1; head advances to the newly written word on the following cycle.
